// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants, types and byte-enable helper for the FPU DMA engine
//
// Purpose: line geometry, DMA state encoding, line data type and the last-beat
// byte-enable helper used by the DMA engine and its address generator.
package fpu_pkg;

  localparam int LINE_BYTES = 64;
  // Buffer row / line-in-row index widths as seen on the buffer ports.
  localparam int ROW_W      = 4;
  localparam int CHUNK_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRN_RD,
    ST_DRN_WR,
    ST_FIL_REQ,
    ST_FIL_WR,
    ST_FIN
  } dma_state_t;

  typedef logic [LINE_BYTES-1:0][7:0] line_t;

  // Byte enables for the final line of a drained row: only the bytes that
  // belong to the row are written; a row ending on a line boundary writes all.
  function automatic logic [LINE_BYTES-1:0] last_be(input logic [9:0] width);
    logic [5:0]            rem;
    logic [LINE_BYTES-1:0] be;
    rem = width[5:0];
    if (rem == 6'd0) be = '1;
    else             be = (64'd1 << rem) - 64'd1;
    return be;
  endfunction

endpackage

// File: rtl/fpu_dma_engine_if.sv
// rtl/fpu_dma_engine_if.sv - request, buffer and memory port bundle of the FPU DMA engine
//
// Purpose: groups the controller request side, the FPUBuffers fill/drain ports
// and the 512-bit memory port.
// Modports:
//   master - the DMA engine (drives busy/done, fill_*, drain_re/row/chunk, mem_*)
//   slave  - the environment (controller, buffers and memory)
interface fpu_dma_engine_if;
  import fpu_pkg::*;

  logic               req_read;
  logic               req_write;
  logic [31:0]        req_read_addr;
  logic [31:0]        req_write_addr;
  logic [9:0]         req_width;
  logic [3:0]         req_height;
  logic [15:0]        in_stride;
  logic [15:0]        out_stride;
  logic               buf_sel;
  logic               making_request;
  logic               job_done;

  logic               fill_we;
  logic [ROW_W-1:0]   fill_row;
  logic [CHUNK_W-1:0] fill_chunk;
  line_t              fill_data;

  logic               drain_re;
  logic [ROW_W-1:0]   drain_row;
  logic [CHUNK_W-1:0] drain_chunk;
  line_t              drain_data;

  logic               mem_req;
  logic               mem_we;
  logic [31:0]        mem_addr;
  line_t              mem_wdata;
  logic [LINE_BYTES-1:0] mem_be;
  logic               mem_ack;
  line_t              mem_rdata;

  modport master (
    input  req_read, req_write, req_read_addr, req_write_addr, req_width, req_height,
           in_stride, out_stride, buf_sel, drain_data, mem_ack, mem_rdata,
    output making_request, job_done, fill_we, fill_row, fill_chunk, fill_data,
           drain_re, drain_row, drain_chunk, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output req_read, req_write, req_read_addr, req_write_addr, req_width, req_height,
           in_stride, out_stride, buf_sel, drain_data, mem_ack, mem_rdata,
    input  making_request, job_done, fill_we, fill_row, fill_chunk, fill_data,
           drain_re, drain_row, drain_chunk, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/fpu_dma_addr_gen.sv
// rtl/fpu_dma_addr_gen.sv - row/chunk walker and byte-address generator for one DMA phase
//
// Purpose: walks rows 0..last_row and chunks 0..last_chunk, producing
//   addr = base + row*stride + chunk*LINE_BYTES (32-bit wrap).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_load                start a new phase (base, stride, limits), counters to 0
//   i_step                advance to the next chunk / row
//   i_base, i_stride      phase base address and row pitch
//   i_last_chunk/row      index of final chunk in a row / final row
//   o_addr, o_row, o_chunk current beat address and indices
//   o_last_chunk          current beat is the final chunk of its row
//   o_last_beat           current beat is the final beat of the phase
module fpu_dma_addr_gen
  import fpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [31:0]        i_base,
  input  logic [15:0]        i_stride,
  input  logic [CHUNK_W-1:0] i_last_chunk,
  input  logic [ROW_W-1:0]   i_last_row,
  output logic [31:0]        o_addr,
  output logic [ROW_W-1:0]   o_row,
  output logic [CHUNK_W-1:0] o_chunk,
  output logic               o_last_chunk,
  output logic               o_last_beat
);

  logic [31:0]        r_row_base;
  logic [15:0]        r_stride;
  logic [ROW_W-1:0]   r_row;
  logic [CHUNK_W-1:0] r_chunk;
  logic [CHUNK_W-1:0] r_last_chunk;
  logic [ROW_W-1:0]   r_last_row;

  // Row base is accumulated one stride per row, so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_base   <= '0;
      r_stride     <= '0;
      r_row        <= '0;
      r_chunk      <= '0;
      r_last_chunk <= '0;
      r_last_row   <= '0;
    end else if (i_load) begin
      r_row_base   <= i_base;
      r_stride     <= i_stride;
      r_row        <= '0;
      r_chunk      <= '0;
      r_last_chunk <= i_last_chunk;
      r_last_row   <= i_last_row;
    end else if (i_step) begin
      if (r_chunk == r_last_chunk) begin
        r_chunk    <= '0;
        r_row      <= r_row + 1'b1;
        r_row_base <= r_row_base + {16'h0, r_stride};
      end else begin
        r_chunk    <= r_chunk + 1'b1;
      end
    end
  end

  assign o_addr       = r_row_base + {{(32-CHUNK_W-6){1'b0}}, r_chunk, 6'b0};
  assign o_row        = r_row;
  assign o_chunk      = r_chunk;
  assign o_last_chunk = (r_chunk == r_last_chunk);
  assign o_last_beat  = o_last_chunk && (r_row == r_last_row);

endmodule

// File: rtl/fpu_dma_engine.sv
// rtl/fpu_dma_engine.sv - drains the write buffer to memory, then fills the idle read buffer
//
// Purpose: on a controller request, writes req_height x ceil(req_width/64) lines
// from the write buffer to the result image, then (if requested) reads
// COL_WIDTH x MEM_BUFFER_WIDTH/64 lines from the source image into the read buffer.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   dif          fpu_dma_engine_if.master (request, fill, drain and memory ports)
//   perf_busy_cycles, perf_beats  saturating counters, only with FPU_DMA_PERF_EN
// Configuration macro: FPU_DMA_PERF_EN adds the performance counters.
module fpu_dma_engine
  import fpu_pkg::*;
#(
  parameter int COL_WIDTH        = 10,
  parameter int MEM_BUFFER_WIDTH = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  fpu_dma_engine_if.master   dif
`ifdef FPU_DMA_PERF_EN
  ,
  output logic [31:0]        perf_busy_cycles,
  output logic [31:0]        perf_beats
`endif
);

  localparam logic [CHUNK_W-1:0] FILL_LAST_CHUNK = CHUNK_W'(MEM_BUFFER_WIDTH / LINE_BYTES - 1);
  localparam logic [ROW_W-1:0]   FILL_LAST_ROW   = ROW_W'(COL_WIDTH - 1);

  dma_state_t   r_state, w_next;
  logic         r_read;
  logic [9:0]   r_width;
  logic [31:0]  r_rd_addr;
  logic [15:0]  r_in_stride;
  logic         r_first;
  line_t        r_wdata;
  line_t        r_rdata;

  logic               w_load, w_step;
  logic [31:0]        w_base;
  logic [15:0]        w_stride;
  logic [CHUNK_W-1:0] w_last_chunk_in;
  logic [ROW_W-1:0]   w_last_row_in;
  logic [31:0]        w_addr;
  logic [ROW_W-1:0]   w_row;
  logic [CHUNK_W-1:0] w_chunk;
  logic               w_last_chunk, w_last_beat;
  logic               w_go_drain, w_mem_req, w_busy;

  fpu_dma_addr_gen u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_base       (w_base),
    .i_stride     (w_stride),
    .i_last_chunk (w_last_chunk_in),
    .i_last_row   (w_last_row_in),
    .o_addr       (w_addr),
    .o_row        (w_row),
    .o_chunk      (w_chunk),
    .o_last_chunk (w_last_chunk),
    .o_last_beat  (w_last_beat)
  );

  // An empty drain (zero width or height) is skipped entirely.
  assign w_go_drain = dif.req_write && (dif.req_width != 10'd0) && (dif.req_height != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_read      <= 1'b0;
      r_width     <= '0;
      r_rd_addr   <= '0;
      r_in_stride <= '0;
      r_first     <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      r_first <= (r_state == ST_DRN_RD);
      if (r_state == ST_IDLE) begin
        r_read      <= dif.req_read;
        r_width     <= dif.req_width;
        r_rd_addr   <= dif.req_read_addr;
        r_in_stride <= dif.in_stride;
      end
      // Drain data is only valid the cycle after drain_re; hold it for the
      // rest of the memory wait.
      if (r_first) r_wdata <= dif.drain_data;
      if ((r_state == ST_FIL_REQ) && dif.mem_ack) r_rdata <= dif.mem_rdata;
    end
  end

  // Fill parameters come from the latched request except when the fill starts
  // straight from IDLE, where the live request is loaded in the capture cycle.
  always_comb begin
    w_next          = r_state;
    w_load          = 1'b0;
    w_step          = 1'b0;
    w_base          = r_rd_addr;
    w_stride        = r_in_stride;
    w_last_chunk_in = FILL_LAST_CHUNK;
    w_last_row_in   = FILL_LAST_ROW;
    case (r_state)
      ST_IDLE: begin
        if (w_go_drain) begin
          w_next          = ST_DRN_RD;
          w_load          = 1'b1;
          w_base          = dif.req_write_addr;
          w_stride        = dif.out_stride;
          w_last_chunk_in = CHUNK_W'((dif.req_width - 10'd1) >> 6);
          w_last_row_in   = dif.req_height - 4'd1;
        end else if (dif.req_read) begin
          w_next   = ST_FIL_REQ;
          w_load   = 1'b1;
          w_base   = dif.req_read_addr;
          w_stride = dif.in_stride;
        end else if (dif.req_write) begin
          w_next = ST_FIN;
        end
      end
      ST_DRN_RD: w_next = ST_DRN_WR;
      ST_DRN_WR: begin
        if (dif.mem_ack) begin
          if (w_last_beat) begin
            if (r_read) begin
              w_next = ST_FIL_REQ;
              w_load = 1'b1;
            end else begin
              w_next = ST_FIN;
            end
          end else begin
            w_next = ST_DRN_RD;
            w_step = 1'b1;
          end
        end
      end
      ST_FIL_REQ: if (dif.mem_ack) w_next = ST_FIL_WR;
      ST_FIL_WR: begin
        if (w_last_beat) begin
          w_next = ST_FIN;
        end else begin
          w_next = ST_FIL_REQ;
          w_step = 1'b1;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_mem_req = (r_state == ST_DRN_WR) || (r_state == ST_FIL_REQ);
  assign w_busy    = (r_state != ST_IDLE) && (r_state != ST_FIN);

  assign dif.making_request = w_busy;
  assign dif.job_done       = (r_state == ST_FIN);

  assign dif.drain_re    = (r_state == ST_DRN_RD);
  assign dif.drain_row   = w_row;
  assign dif.drain_chunk = w_chunk;

  assign dif.fill_we    = (r_state == ST_FIL_WR);
  assign dif.fill_row   = w_row;
  assign dif.fill_chunk = w_chunk;
  assign dif.fill_data  = r_rdata;

  assign dif.mem_req   = w_mem_req;
  assign dif.mem_we    = (r_state == ST_DRN_WR);
  assign dif.mem_addr  = w_mem_req ? w_addr : 32'h0;
  assign dif.mem_wdata = (r_state != ST_DRN_WR) ? '0 :
                         (r_first ? dif.drain_data : r_wdata);
  assign dif.mem_be    = (r_state == ST_FIL_REQ) ? '1 :
                         (r_state != ST_DRN_WR)  ? '0 :
                         (w_last_chunk ? last_be(r_width) : '1);

`ifdef FPU_DMA_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_beats;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_busy  <= '0;
      r_perf_beats <= '0;
    end else begin
      if (w_busy && (r_perf_busy != 32'hFFFF_FFFF)) r_perf_busy <= r_perf_busy + 32'd1;
      if (w_mem_req && dif.mem_ack && (r_perf_beats != 32'hFFFF_FFFF))
        r_perf_beats <= r_perf_beats + 32'd1;
    end
  end

  assign perf_busy_cycles = r_perf_busy;
  assign perf_beats       = r_perf_beats;
`endif

endmodule

// File: tb/tb_fpu_dma_engine.sv
// tb/tb_fpu_dma_engine.sv - randomized self-checking bench for fpu_dma_engine
`timescale 1ns/1ps
module tb_fpu_dma_engine;
  import fpu_pkg::*;

  localparam int COLW = 10;
  localparam int NCH  = 8;
  localparam int DONE_BOUND = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_dma_engine_if dif ();

`ifdef FPU_DMA_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_beats;
`endif

  fpu_dma_engine #(.COL_WIDTH(COLW), .MEM_BUFFER_WIDTH(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
`ifdef FPU_DMA_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_beats       (perf_beats)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [63:0]  be;
    logic [511:0] wdata;
    int           row;
    int           chunk;
  } beat_t;

  typedef struct {
    int           row;
    int           chunk;
    logic [511:0] data;
  } fill_t;

  beat_t        exp_mem[$];
  fill_t        exp_fill[$];
  logic [511:0] wbuf [16][8];

  bit hold_ack = 1'b0;
  int ack_max  = 100;

  // Reference model: list of memory beats the job must produce, in order.
  task automatic build_model(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] wa,
                             input int w, input int h, input logic [15:0] ist, input logic [15:0] ost);
    beat_t b;
    int nch;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) wbuf[r][c] = rand512();
    if (wr && w > 0 && h > 0) begin
      nch = (w + 63) / 64;
      for (int r = 0; r < h; r++)
        for (int c = 0; c < nch; c++) begin
          b.we    = 1'b1;
          b.addr  = wa + 32'(r) * {16'h0, ost} + 32'(c) * 32'd64;
          b.be    = (c == nch - 1 && (w % 64) != 0) ? ((64'd1 << (w % 64)) - 64'd1) : '1;
          b.wdata = wbuf[r][c];
          b.row   = r;
          b.chunk = c;
          exp_mem.push_back(b);
        end
    end
    if (rd) begin
      for (int r = 0; r < COLW; r++)
        for (int c = 0; c < NCH; c++) begin
          b.we    = 1'b0;
          b.addr  = ra + 32'(r) * {16'h0, ist} + 32'(c) * 32'd64;
          b.be    = '1;
          b.wdata = '0;
          b.row   = r;
          b.chunk = c;
          exp_mem.push_back(b);
        end
    end
  endtask

  task automatic start_req(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] wa,
                           input int w, input int h, input logic [15:0] ist, input logic [15:0] ost);
    @(negedge clk);
    dif.req_read       = rd;
    dif.req_write      = wr;
    dif.req_read_addr  = ra;
    dif.req_write_addr = wa;
    dif.req_width      = 10'(w);
    dif.req_height     = 4'(h);
    dif.in_stride      = ist;
    dif.out_stride     = ost;
    dif.buf_sel        = 1'($urandom);
  endtask

  // Drop the request level and disturb the other request inputs; the job
  // must keep using the values captured in IDLE.
  task automatic drop_req();
    dif.req_read       = 1'b0;
    dif.req_write      = 1'b0;
    dif.req_read_addr  = $urandom;
    dif.req_write_addr = $urandom;
    dif.req_width      = 10'($urandom_range(0, 512));
    dif.req_height     = 4'($urandom_range(0, 8));
    dif.in_stride      = 16'($urandom);
    dif.out_stride     = 16'($urandom);
  endtask

  task automatic run_job(input string name, input bit rd, input bit wr, input logic [31:0] ra,
                         input logic [31:0] wa, input int w, input int h, input logic [15:0] ist,
                         input logic [15:0] ost, input int max_cyc);
    int cyc;
    bit seen;
    bit exp_busy;
    exp_busy = (wr && w > 0 && h > 0) || rd;
    build_model(rd, wr, ra, wa, w, h, ist, ost);
    start_req(rd, wr, ra, wa, w, h, ist, ost);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < DONE_BOUND) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check_eq({name, ":busy_after_capture"}, dif.making_request, exp_busy);
        drop_req();
      end
      if (dif.job_done) seen = 1'b1;
    end
    check_eq({name, ":job_done_seen"}, seen, 1'b1);
    check_eq({name, ":busy_in_fin"}, dif.making_request, 1'b0);
    if (max_cyc > 0) check_eq({name, ":fin_latency_ok"}, (cyc <= max_cyc), 1'b1);
    @(negedge clk);
    check_eq({name, ":done_single_pulse"}, dif.job_done, 1'b0);
    check_eq({name, ":idle_busy"}, dif.making_request, 1'b0);
    check_eq({name, ":idle_mem_req"}, dif.mem_req, 1'b0);
    check_eq({name, ":beats_left"}, exp_mem.size(), 0);
    check_eq({name, ":fills_left"}, exp_fill.size(), 0);
  endtask

  // Memory responder: checks each new request against the model, checks the
  // request stays stable while waiting, acks after 1..ack_max cycles.
  bit           pend = 1'b0;
  bit           have_cur = 1'b0;
  int           dly = 0;
  beat_t        cur;
  logic [96:0]  snap_ctl;
  logic [511:0] snap_wd;
  fill_t        fnew;

  initial begin
    dif.mem_ack   = 1'b0;
    dif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      dif.mem_ack   = 1'b0;
      dif.mem_rdata = rand512();
      if (!rst_n) begin
        pend = 1'b0;
      end else if (dif.mem_req) begin
        if (!pend) begin
          pend     = 1'b1;
          dly      = $urandom_range(1, ack_max);
          snap_ctl = {dif.mem_we, dif.mem_addr, dif.mem_be};
          snap_wd  = dif.mem_wdata;
          if (exp_mem.size() == 0) begin
            have_cur = 1'b0;
            check_eq("unexpected_mem_req", dif.mem_req, 1'b0);
          end else begin
            have_cur = 1'b1;
            cur = exp_mem.pop_front();
            check_eq("beat_we", dif.mem_we, cur.we);
            check_eq("beat_addr", dif.mem_addr, cur.addr);
            check_eq("beat_be", dif.mem_be, cur.be);
            if (cur.we) check_eq("beat_wdata", dif.mem_wdata, cur.wdata);
          end
        end else begin
          check_eq("req_hold_ctl", {dif.mem_we, dif.mem_addr, dif.mem_be}, snap_ctl);
          if (snap_ctl[96]) check_eq("req_hold_wdata", dif.mem_wdata, snap_wd);
        end
        if (!hold_ack) begin
          dly--;
          if (dly == 0) begin
            dif.mem_ack = 1'b1;
            pend = 1'b0;
            if (have_cur && !cur.we) begin
              fnew.row   = cur.row;
              fnew.chunk = cur.chunk;
              fnew.data  = dif.mem_rdata;
              exp_fill.push_back(fnew);
            end
          end
        end
      end
    end
  end

  // Write buffer: data appears one cycle after drain_re, garbage otherwise.
  initial begin
    bit pend_rd;
    int prow, pch;
    dif.drain_data = '0;
    forever begin
      @(negedge clk);
      pend_rd = dif.drain_re;
      prow    = int'(dif.drain_row);
      pch     = int'(dif.drain_chunk);
      @(posedge clk);
      #1;
      if (pend_rd) dif.drain_data = wbuf[prow][pch];
      else         dif.drain_data = rand512();
    end
  end

  // Read buffer: every fill write must match the line returned at its ack.
  initial begin
    fill_t f;
    forever begin
      @(negedge clk);
      if (rst_n && dif.fill_we) begin
        if (exp_fill.size() == 0) begin
          check_eq("unexpected_fill_we", dif.fill_we, 1'b0);
        end else begin
          f = exp_fill.pop_front();
          check_eq("fill_row", dif.fill_row, f.row);
          check_eq("fill_chunk", dif.fill_chunk, f.chunk);
          check_eq("fill_data", dif.fill_data, f.data);
        end
      end
    end
  end

  initial begin
    bit seen;
    int rd, wr;
    dif.req_read = 1'b0;
    dif.req_write = 1'b0;
    dif.req_read_addr = '0;
    dif.req_write_addr = '0;
    dif.req_width = '0;
    dif.req_height = '0;
    dif.in_stride = '0;
    dif.out_stride = '0;
    dif.buf_sel = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", dif.making_request, 1'b0);
    check_eq("rst_job_done", dif.job_done, 1'b0);
    check_eq("rst_mem_req", dif.mem_req, 1'b0);
    check_eq("rst_mem_we", dif.mem_we, 1'b0);
    check_eq("rst_mem_addr", dif.mem_addr, 32'h0);
    check_eq("rst_mem_be", dif.mem_be, 64'h0);
    check_eq("rst_fill_we", dif.fill_we, 1'b0);
    check_eq("rst_drain_re", dif.drain_re, 1'b0);
    rst_n = 1'b1;

    // No request: engine stays idle.
    repeat (5) begin
      @(negedge clk);
      dif.req_read_addr = $urandom;
      dif.req_width = 10'($urandom_range(1, 512));
      dif.req_height = 4'($urandom_range(1, 8));
      check_eq("noreq_busy", dif.making_request, 1'b0);
      check_eq("noreq_mem_req", dif.mem_req, 1'b0);
    end

    run_job("t1_drain", 0, 1, 32'h0, 32'h100, 480, 8, 16'd1446, 16'd484, 0);
    run_job("t2_fill", 1, 0, 32'h2000, 32'h0, 160, 8, 16'd486, 16'd484, 0);
    run_job("t3_both", 1, 1, 32'h4000, 32'h8000, 64, 1, 16'd198, 16'd196, 0);
    run_job("t4_w0", 0, 1, 32'h0, 32'h300, 0, 5, 16'd6, 16'd4, 2);
    run_job("t4_h0", 0, 1, 32'h0, 32'h300, 100, 0, 16'd306, 16'd304, 2);

    // Reset while a drain write is waiting for ack.
    hold_ack = 1'b1;
    build_model(0, 1, 32'h0, 32'h5000, 128, 2, 16'd390, 16'd388);
    start_req(0, 1, 32'h0, 32'h5000, 128, 2, 16'd390, 16'd388);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) drop_req();
      if (dif.mem_req && dif.mem_we) seen = 1'b1;
    end
    check_eq("t5_reached_drn_wr", seen, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_rst_mem_req", dif.mem_req, 1'b0);
    check_eq("t5_rst_busy", dif.making_request, 1'b0);
    check_eq("t5_rst_done", dif.job_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_ack = 1'b0;
    exp_mem.delete();
    exp_fill.delete();
    run_job("t5_after", 0, 1, 32'h0, 32'h6000, 200, 2, 16'd606, 16'd604, 0);

    run_job("t6_wrap", 1, 0, 32'hFFFF_FFC0, 32'h0, 160, 8, 16'd486, 16'd484, 0);

    ack_max = 8;
    for (int j = 0; j < 3; j++) begin
      rd = $urandom_range(0, 1);
      wr = (rd == 0) ? 1 : $urandom_range(0, 1);
      run_job("rand", 1'(rd), 1'(wr), $urandom, $urandom, $urandom_range(0, 512),
              $urandom_range(0, 8), 16'($urandom), 16'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
